dm_unit: RTL and testbench
==========================

Name: dm_unit

Overview:
Data memory for the single-cycle MIPS datapath. It sits directly downstream of the ALU and uses ALUResult as the byte address.
- Stores: synchronous, word/half/byte, with byte-lane merge into the addressed word.
- Loads: combinational, with sign/zero extension.
- Address errors: flags misaligned and out-of-range accesses and suppresses the corresponding store.
- Write trace: emits a registered one-cycle record of every committed store for the bench.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words in the array.
IDX_BITS, 12, word-index width; must satisfy 2**IDX_BITS >= DEPTH_WORDS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
MemWrite  input  1  store request for this cycle.
DMOp  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 reserved.
Addr  input  32  byte address, driven from ALUResult.
WD  input  32  store data; the low half or low byte is used for sub-word stores.
PC  input  32  address of the current instruction; captured in the trace only.
RD  output  32  extended load data (combinational).
AddrErr  output  1  combinational; 1 when the current access is illegal.
dbg_we  output  1  registered; 1 for one cycle after a committed store.
dbg_pc  output  32  registered PC of the committed store.
dbg_addr  output  32  registered word-aligned address of the committed store (Addr with bits [1:0] cleared).
dbg_data  output  32  registered full merged word as written.

Behaviour:
- Word index = Addr[IDX_BITS+1:2].
- Range: the access is out of range when Addr >= DEPTH_WORDS*4. Addr[31:IDX_BITS+2] nonzero is therefore out of range.
- Alignment:
  - word needs Addr[1:0] == 00;
  - half needs Addr[0] == 0;
  - byte is always aligned.
- AddrErr = out_of_range | misaligned | (DMOp reserved).
  - AddrErr is evaluated every cycle, regardless of MemWrite.
- Load path, combinational:
  - word: RD = mem[idx].
  - half: selects bits [15:0] when Addr[1] = 0, bits [31:16] when Addr[1] = 1; then sign- or zero-extends.
  - byte: lane Addr[1:0] (00 is bits [7:0], 11 is bits [31:24]); then sign- or zero-extends.
  - RD = 0 whenever AddrErr = 1.
- Store path, on the rising edge when MemWrite = 1 and AddrErr = 0 and reset = 0:
  - word: mem[idx] = WD.
  - half: WD[15:0] replaces the selected half.
  - byte: WD[7:0] replaces the selected lane.
  - All other lanes are preserved (read-modify-write within one cycle).
- Illegal store: when MemWrite = 1 and AddrErr = 1, the array is unchanged and dbg_we = 0 next cycle.
- Read during write, same cycle: RD shows the pre-write contents. The new value is visible from the next cycle.
- Trace registers: on a committed store, dbg_we = 1, dbg_pc = PC, dbg_addr = {Addr[31:2], 2'b00}, dbg_data = merged word. Otherwise dbg_we = 0 and the dbg_pc/addr/data registers hold their previous values.
- Reset, synchronous:
  - At the edge with reset = 1, every array word is cleared to 0.
  - dbg_we, dbg_pc, dbg_addr and dbg_data are cleared to 0.
  - reset has priority over a simultaneous MemWrite; that store is dropped.
  - Consequence: after reset, RD = 0 for any legal address. AddrErr stays combinational and valid during reset.
- Reset mid-program: the memory contents are lost; there is no partial clear.
- No stall or handshake: one access per cycle, single-cycle latency for stores, zero latency for loads.

Test Plan:
- Reset then read: assert reset for 1 cycle, release. Addr = 0x0000_0000, DMOp = 000 → RD = 0x0000_0000, AddrErr = 0, dbg_we = 0.
- Word store then sub-word loads: sw WD = 0x8765_43A1 @ 0x10.
  - Next cycle: dbg_we = 1, dbg_addr = 0x10, dbg_data = 0x8765_43A1.
  - Loads: lb @ 0x10 → 0xFFFF_FFA1; lbu @ 0x10 → 0x0000_00A1; lh @ 0x12 → 0xFFFF_8765; lhu @ 0x12 → 0x0000_8765.
- Sub-word merge: on the word holding 0x8765_43A1, sb WD = 0x1234_56EE @ 0x11, then sh WD = 0x0000_BEEF @ 0x12 → lw @ 0x10 = 0xBEEF_EEA1. The sh trace shows dbg_data = 0xBEEF_EEA1.
- Misaligned/out-of-range: each of these gives AddrErr = 1 and RD = 0, and the array is unchanged:
  - sw @ 0x13;
  - sh @ 0x15;
  - sw @ 0x0000_3000 (= DEPTH_WORDS*4);
  - DMOp = 111.
  - dbg_we = 0 on the following cycle.
- Read-during-write: with mem[0x20] = 0x1111_1111, drive sw WD = 0x2222_2222 @ 0x20 and sample RD before the edge → 0x1111_1111. After the edge → 0x2222_2222.
- Reset wins: reset = 1 together with sw 0xDEAD_BEEF @ 0x40 → after the edge lw @ 0x40 = 0 and dbg_we = 0. A previously written word @ 0x10 also reads 0.

Source files
------------

// File: rtl/dm_unit_if.sv
// Bus bundle for the MIPS data memory: access request, load result and store trace.
interface dm_unit_if;
    logic        MemWrite;
    logic [2:0]  DMOp;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] RD;
    logic        AddrErr;
    logic        dbg_we;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_data;

    modport master (
        output MemWrite, DMOp, Addr, WD, PC,
        input  RD, AddrErr, dbg_we, dbg_pc, dbg_addr, dbg_data
    );

    modport slave (
        input  MemWrite, DMOp, Addr, WD, PC,
        output RD, AddrErr, dbg_we, dbg_pc, dbg_addr, dbg_data
    );
endinterface

// File: rtl/dm_unit.sv
// Data memory for the single-cycle MIPS datapath: synchronous word/half/byte stores,
// combinational extended loads, address-error detection and a registered store trace.
module dm_unit #(
    parameter int DEPTH_WORDS = 3072,
    parameter int IDX_BITS    = 12
) (
    input  logic      clk,
    input  logic      reset,
    dm_unit_if.slave  bus
);

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_B  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_BITS-1:0] idx;
    logic                out_of_range;
    logic                misaligned;
    logic                addr_err;
    logic [31:0]         word_rd;
    logic [15:0]         half_rd;
    logic [7:0]          byte_rd;
    logic [4:0]          lane_off;
    logic [31:0]         load_data;
    logic [31:0]         merged;
    logic                commit;

    logic        dbg_we_q;
    logic [31:0] dbg_pc_q;
    logic [31:0] dbg_addr_q;
    logic [31:0] dbg_data_q;

    assign idx          = bus.Addr[IDX_BITS+1:2];
    assign out_of_range = (bus.Addr >= ADDR_LIMIT);
    assign lane_off     = {bus.Addr[1:0], 3'b000};

    // Reserved opcodes are folded into misaligned so AddrErr covers them too.
    always_comb begin
        misaligned = 1'b0;
        case (bus.DMOp)
            OP_W:        misaligned = (bus.Addr[1:0] != 2'b00);
            OP_H, OP_HU: misaligned = bus.Addr[0];
            OP_B, OP_BU: misaligned = 1'b0;
            default:     misaligned = 1'b1;
        endcase
    end

    assign addr_err = out_of_range | misaligned;

    // Guard the array read so an out-of-range index never reaches mem.
    assign word_rd = out_of_range ? 32'h0 : mem[idx];
    assign half_rd = bus.Addr[1] ? word_rd[31:16] : word_rd[15:0];
    assign byte_rd = word_rd[lane_off +: 8];

    always_comb begin
        load_data = 32'h0;
        case (bus.DMOp)
            OP_W:    load_data = word_rd;
            OP_H:    load_data = {{16{half_rd[15]}}, half_rd};
            OP_HU:   load_data = {16'h0, half_rd};
            OP_B:    load_data = {{24{byte_rd[7]}}, byte_rd};
            OP_BU:   load_data = {24'h0, byte_rd};
            default: load_data = 32'h0;
        endcase
        if (addr_err) begin
            load_data = 32'h0;
        end
    end

    always_comb begin
        merged = word_rd;
        case (bus.DMOp)
            OP_W: merged = bus.WD;
            OP_H, OP_HU: begin
                if (bus.Addr[1]) merged[31:16] = bus.WD[15:0];
                else             merged[15:0]  = bus.WD[15:0];
            end
            OP_B, OP_BU: merged[lane_off +: 8] = bus.WD[7:0];
            default: merged = word_rd;
        endcase
    end

    assign commit = bus.MemWrite & ~addr_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
            dbg_we_q   <= 1'b0;
            dbg_pc_q   <= 32'h0;
            dbg_addr_q <= 32'h0;
            dbg_data_q <= 32'h0;
        end else begin
            dbg_we_q <= commit;
            if (commit) begin
                mem[idx]   <= merged;
                dbg_pc_q   <= bus.PC;
                dbg_addr_q <= {bus.Addr[31:2], 2'b00};
                dbg_data_q <= merged;
            end
        end
    end

    assign bus.RD       = load_data;
    assign bus.AddrErr  = addr_err;
    assign bus.dbg_we   = dbg_we_q;
    assign bus.dbg_pc   = dbg_pc_q;
    assign bus.dbg_addr = dbg_addr_q;
    assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: vector table for loads/stores/errors, a trace
// scoreboard for the registered store record, and hand sequences around reset.
module tb_dm_unit;

    logic clk;
    logic reset;

    dm_unit_if bus ();

    dm_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] tdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_t;

    int checks = 0;
    int errors = 0;

    vec_t   vecs [$];
    trace_t sb_q [$];
    trace_t last_commit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err,
                       input logic [31:0] tdata);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wd = wd;
        v.rd = rd; v.err = err; v.tdata = tdata;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        bus.MemWrite = 1'b0;
        bus.DMOp     = 3'b000;
        bus.Addr     = 32'h0;
        bus.WD       = 32'h0;
        bus.PC       = 32'h0;
    endtask

    // Compare the registered trace against the next scoreboard entry.
    task automatic check_trace(input string tag);
        trace_t t;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty act=%0d exp=1", tag, sb_q.size());
            return;
        end
        t = sb_q.pop_front();
        chk({tag, " dbg_we"}, {31'h0, bus.dbg_we}, {31'h0, t.we});
        if (t.we) last_commit = t;
        chk({tag, " dbg_pc"},   bus.dbg_pc,   last_commit.pc);
        chk({tag, " dbg_addr"}, bus.dbg_addr, last_commit.addr);
        chk({tag, " dbg_data"}, bus.dbg_data, last_commit.data);
    endtask

    initial begin
        trace_t t;
        string  tag;

        // we, op, addr, wd, expected RD (pre-edge), expected AddrErr, expected trace data
        add(0, 3'd0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0, 32'h0);
        add(1, 3'd0, 32'h0000_0010, 32'h8765_43A1, 32'h0000_0000, 0, 32'h8765_43A1);
        add(0, 3'd3, 32'h0000_0010, 32'h0,         32'hFFFF_FFA1, 0, 32'h0);
        add(0, 3'd4, 32'h0000_0010, 32'h0,         32'h0000_00A1, 0, 32'h0);
        add(0, 3'd1, 32'h0000_0012, 32'h0,         32'hFFFF_8765, 0, 32'h0);
        add(0, 3'd2, 32'h0000_0012, 32'h0,         32'h0000_8765, 0, 32'h0);
        add(0, 3'd0, 32'h0000_0010, 32'h0,         32'h8765_43A1, 0, 32'h0);
        add(1, 3'd3, 32'h0000_0011, 32'h1234_56EE, 32'h0000_0043, 0, 32'h8765_EEA1);
        add(1, 3'd1, 32'h0000_0012, 32'h0000_BEEF, 32'hFFFF_8765, 0, 32'hBEEF_EEA1);
        add(0, 3'd0, 32'h0000_0010, 32'h0,         32'hBEEF_EEA1, 0, 32'h0);
        add(1, 3'd0, 32'h0000_0013, 32'hCAFE_F00D, 32'h0000_0000, 1, 32'h0);
        add(1, 3'd1, 32'h0000_0015, 32'hCAFE_F00D, 32'h0000_0000, 1, 32'h0);
        add(1, 3'd0, 32'h0000_3000, 32'hCAFE_F00D, 32'h0000_0000, 1, 32'h0);
        add(1, 3'd7, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1, 32'h0);
        add(0, 3'd0, 32'h0000_0010, 32'h0,         32'hBEEF_EEA1, 0, 32'h0);
        add(0, 3'd2, 32'h0000_0011, 32'h0,         32'h0000_0000, 1, 32'h0);
        add(1, 3'd0, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 0, 32'h1111_1111);
        add(1, 3'd0, 32'h0000_0020, 32'h2222_2222, 32'h1111_1111, 0, 32'h2222_2222);
        add(0, 3'd0, 32'h0000_0020, 32'h0,         32'h2222_2222, 0, 32'h0);
        add(1, 3'd3, 32'h0000_2FFF, 32'h0000_005A, 32'h0000_0000, 0, 32'h5A00_0000);
        add(0, 3'd4, 32'h0000_2FFF, 32'h0,         32'h0000_005A, 0, 32'h0);
        add(0, 3'd0, 32'h0000_2FFC, 32'h0,         32'h5A00_0000, 0, 32'h0);
        add(0, 3'd5, 32'h0000_0010, 32'h0,         32'h0000_0000, 1, 32'h0);
        add(0, 3'd0, 32'hFFFF_FFF0, 32'h0,         32'h0000_0000, 1, 32'h0);
        add(1, 3'd2, 32'h0000_0016, 32'h0000_FFFF, 32'h0000_0000, 0, 32'hFFFF_0000);
        add(0, 3'd1, 32'h0000_0016, 32'h0,         32'hFFFF_FFFF, 0, 32'h0);
        add(0, 3'd3, 32'h0000_0014, 32'h0,         32'h0000_0000, 0, 32'h0);

        last_commit = '{we: 1'b0, pc: 32'h0, addr: 32'h0, data: 32'h0};
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset dbg_we",   {31'h0, bus.dbg_we}, 32'h0);
        chk("reset dbg_data", bus.dbg_data, 32'h0);
        chk("reset dbg_addr", bus.dbg_addr, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.MemWrite = vecs[i].we;
            bus.DMOp     = vecs[i].op;
            bus.Addr     = vecs[i].addr;
            bus.WD       = vecs[i].wd;
            bus.PC       = 32'h0000_0400 + 32'(i * 4);
            t.we   = vecs[i].we & ~vecs[i].err;
            t.pc   = bus.PC;
            t.addr = {vecs[i].addr[31:2], 2'b00};
            t.data = vecs[i].tdata;
            sb_q.push_back(t);
            #1;
            $sformat(tag, "v%0d", i);
            chk({tag, " RD"},      bus.RD, vecs[i].rd);
            chk({tag, " AddrErr"}, {31'h0, bus.AddrErr}, {31'h0, vecs[i].err});
            @(posedge clk);
            #1;
            check_trace(tag);
        end

        // Reset together with a legal store: store dropped, trace cleared.
        @(negedge clk);
        reset        = 1'b1;
        bus.MemWrite = 1'b1;
        bus.DMOp     = 3'b000;
        bus.Addr     = 32'h0000_0040;
        bus.WD       = 32'hDEAD_BEEF;
        bus.PC       = 32'h0000_0800;
        @(posedge clk);
        #1;
        chk("rst_wins dbg_we",   {31'h0, bus.dbg_we}, 32'h0);
        chk("rst_wins dbg_data", bus.dbg_data, 32'h0);
        chk("rst_wins dbg_pc",   bus.dbg_pc, 32'h0);
        // AddrErr stays live while reset is held.
        bus.Addr = 32'h0000_0013;
        #1;
        chk("rst AddrErr live", {31'h0, bus.AddrErr}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        bus.Addr = 32'h0000_0040;
        #1;
        chk("rst_wins lw 0x40", bus.RD, 32'h0);
        bus.Addr = 32'h0000_0010;
        #1;
        chk("rst lw 0x10", bus.RD, 32'h0);
        bus.Addr = 32'h0000_2FFC;
        #1;
        chk("rst lw 0x2FFC", bus.RD, 32'h0);

        // Fresh store after reset commits normally with one-cycle trace pulse.
        @(negedge clk);
        bus.MemWrite = 1'b1;
        bus.Addr     = 32'h0000_0044;
        bus.WD       = 32'h0BAD_F00D;
        bus.PC       = 32'h0000_0900;
        @(posedge clk);
        #1;
        chk("post dbg_we",   {31'h0, bus.dbg_we}, 32'h1);
        chk("post dbg_addr", bus.dbg_addr, 32'h0000_0044);
        chk("post dbg_data", bus.dbg_data, 32'h0BAD_F00D);
        @(negedge clk);
        idle_inputs();
        bus.Addr = 32'h0000_0044;
        #1;
        chk("post lw 0x44", bus.RD, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        chk("post dbg_we drop", {31'h0, bus.dbg_we}, 32'h0);
        chk("post dbg_pc hold", bus.dbg_pc, 32'h0000_0900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
